// File: rtl/imm_pkg.sv
// Shared immediate-format encodings and XLEN configuration helpers.
package imm_pkg;

  // imm_src encodings, also used by the control decoder.
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_Z    = 3'b101;
  localparam logic [2:0] IMM_SH   = 3'b110;
  localparam logic [2:0] IMM_RSVD = 3'b111;

  localparam int unsigned IMM_XLEN_RV32 = 32;
  localparam int unsigned IMM_XLEN_RV64 = 64;

  // True only for the datapath widths the decoder supports.
  function automatic logic imm_xlen_ok(input int unsigned xlen);
    return (xlen == IMM_XLEN_RV32) || (xlen == IMM_XLEN_RV64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake and data bundle between decode, the immediate pipe and register read.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  // Producer/consumer side.
  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  // Immediate pipe side.
  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extractor: instruction + format select -> XLEN immediate.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_src_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [31:0] sext_raw;
  logic [31:0] zext_raw;
  logic        use_sext;

  // Build a 32-bit field (already sign-extended where needed), then widen to XLEN.
  always_comb begin
    sext_raw  = '0;
    zext_raw  = '0;
    use_sext  = 1'b0;
    // An unsupported XLEN marks every entry illegal rather than emitting garbage.
    illegal_o = !imm_xlen_ok(XLEN);
    case (imm_src_i)
      IMM_I: begin
        use_sext = 1'b1;
        sext_raw = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      IMM_S: begin
        use_sext = 1'b1;
        sext_raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      IMM_B: begin
        use_sext = 1'b1;
        sext_raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
      end
      IMM_J: begin
        use_sext = 1'b1;
        sext_raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
      end
      IMM_U: begin
        use_sext = 1'b1;
        sext_raw = {instr_i[31:12], 12'b0};
      end
      IMM_Z: begin
        zext_raw = {27'b0, instr_i[19:15]};
      end
      IMM_SH: begin
        // RV64 shamt is 6 bits; RV32 ignores bit 25.
        zext_raw = (XLEN == IMM_XLEN_RV64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  // Final widening: arithmetic for signed formats, logical otherwise.
  always_comb begin
    imm_o = use_sext ? XLEN'($signed(sext_raw)) : XLEN'(zext_raw);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one decode stage feeding a main register plus skid
// register so the upstream ready never depends combinationally on the consumer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_gen_pipe_if.slave bus
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;

  logic             accept;
  logic             consume;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i   (bus.in_instr),
    .imm_src_i (bus.in_imm_src),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal)
  );

  // in_ready is the inverse of a flop, so it is registered by construction.
  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_imm     = main_imm_q;
  assign bus.out_tag     = main_tag_q;
  assign bus.out_illegal = main_ill_q;

  assign accept  = bus.in_valid && !skid_valid_q;
  assign consume = main_valid_q && bus.out_ready;

  // Next-state for main/skid; flush beats consume beats accept.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume && skid_valid_q) begin
      // Skid full implies in_ready low, so no accept can coincide here.
      main_valid_d = 1'b1;
      main_imm_d   = skid_imm_q;
      main_tag_d   = skid_tag_q;
      main_ill_d   = skid_ill_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || consume)) begin
      main_valid_d = 1'b1;
      main_imm_d   = dec_imm;
      main_tag_d   = bus.in_tag;
      main_ill_d   = dec_illegal;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = bus.in_tag;
      skid_ill_d   = dec_illegal;
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; asynchronous reset discards both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It sits between the instruction register and the register-read stage. It extracts and extends every RV32/RV64 base immediate format (I, S, B, J, U, CSR-uimm, shift-amount) to XLEN bits. A one-cycle registered path with a valid/ready handshake and a 2-entry skid buffer carries a sideband tag alongside the result, so the decode stage can stall without a combinational ready path.

## Interface
Parameters:
- XLEN, 32, output datapath width; legal values 32 or 64.
- TAG_W, 8, width of sideband tag carried with each instruction (e.g. ROB index or rd).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction/imm_src/tag presented.
- in_ready  out  1  block can accept; registered, never combinationally dependent on out_ready.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR uimm), 110 SH (shamt), 111 reserved.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the entry on out_imm.
- out_illegal  out  1  entry used imm_src 111.

## Operation
- Sign extension from instr[31] to XLEN for I, S, B, J, U:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - U: {instr[31:12], 12'b0}, sign-extended for XLEN=64.
- Zero extension for the remaining formats:
  - Z: instr[19:15].
  - SH: instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
- Reserved 111: out_imm=0, out_illegal=1; the entry still flows through the handshake.
- Storage: main register (drives outputs) plus one skid register. Entries leave in arrival order.
- Accept when in_valid && in_ready. Consume when out_valid && out_ready.
- Accept, with main empty or being consumed: the entry loads main.
- Accept, with main held (out_valid && !out_ready): the entry loads skid.
- Consume with skid full: skid moves to main in the same edge.
- in_ready = !skid_valid, registered.
- flush=1: both valid bits clear at the edge. An input presented in the same cycle is dropped even if in_ready=1. flush has priority over accept and consume.

## Timing
- Latency: accepted at edge N → out_valid=1 with the result after edge N.
- Throughput: 1 per cycle while out_ready=1.
- While out_valid && !out_ready, out_imm, out_tag and out_illegal hold stable.
- in_ready falls the cycle after the skid fills. It rises the cycle after the skid drains.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0; skid_valid=0.
- Reset mid-operation discards both entries immediately, with no partial output.
- Simultaneous accept and consume with skid empty: main is replaced, and out_valid stays 1.

## Structure
- Shared package imm_pkg holds:
  - IMM_I..IMM_SH and IMM_RSVD 3-bit localparams (used by the control decoder too).
  - XLEN legality check constant.
- Sub-module imm_decode: purely combinational, parametrised by XLEN (instr, imm_src → imm, illegal). It is instantiated once ahead of the main/skid registers and is reusable by the compressed-instruction expander.
- Top level holds only handshake/skid state. No FSM beyond the two valid bits: empty, one held, two held.

## Test plan
- XLEN=32, I 0xFFF00093 → 0xFFFFFFFF one cycle later; S 0x00112623 → 0x0000000C; B 0xFE000EE3 → 0xFFFFFFFC; J 0x0080006F → 0x00000008.
- XLEN=64, U 0x80000037 → 0xFFFFFFFF80000000; SH 0x03F01013 → 0x3F; Z 0x3401D073 → 0x3 (zero-extended).
- imm_src=111, any instr → out_imm=0, out_illegal=1, tag preserved.
- Back-to-back stream of 8 tags 0..7:
  - out_ready low for 3 cycles, then high.
  - in_ready drops one cycle after the second entry is held.
  - Output order is 0..7; nothing is lost or duplicated.
- flush with both registers full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- rst_n asserted asynchronously mid-stream → outputs go to reset values without waiting for a clock edge; the first input after release appears 1 cycle after acceptance.
